// File: rtl/conv_seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv_seq_ctrl_if                                           |
// | Description : Control/handshake bundle between the conv sequencer, the   |
// |               host start strobes, the input buffer and the conv engine.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface conv_seq_ctrl_if #(
  parameter int N_CH   = 3,
  parameter int ADDR_W = 12
);
  localparam int CH_W = $clog2(N_CH) + 1;

  // Host strobes
  logic              start_operation;
  logic              start_load_img;
  logic              clear_weights;
  logic              abort;
  // Buffer read port
  logic              rd_req;
  logic              rd_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic              img_weight_sel;
  // Conv engine handshake
  logic [CH_W-1:0]   ch_idx;
  logic              conv_start;
  logic              conv_done;
  // Status
  logic              weights_loaded;
  logic              busy;
  logic              done;
  logic [31:0]       perf_cycles;

  // Sequencer side
  modport master (
    input  start_operation, start_load_img, clear_weights, abort, rd_ack, conv_done,
    output rd_req, rd_addr, img_weight_sel, ch_idx, conv_start,
           weights_loaded, busy, done, perf_cycles
  );

  // Environment side (host, buffer, engine)
  modport slave (
    output start_operation, start_load_img, clear_weights, abort, rd_ack, conv_done,
    input  rd_req, rd_addr, img_weight_sel, ch_idx, conv_start,
           weights_loaded, busy, done, perf_cycles
  );
endinterface
`default_nettype wire

// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv_seq_ctrl                                              |
// | Description : Sequencer for the conv datapath. Loads all weights once,   |
// |               then per channel reads an image tile and runs one conv.    |
// |               Word reads use req/ack with internal per-phase counters.   |
// | Options     : CONV_SEQ_PERF_CNT_EN - builds the saturating busy-cycle    |
// |               counter on perf_cycles (tied to 0 when undefined).         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module conv_seq_ctrl #(
  parameter int N_CH    = 3,
  parameter int W_WORDS = 9,
  parameter int I_WORDS = 784,
  parameter int ADDR_W  = 12
) (
  input logic             clk,
  input logic             rst,
  conv_seq_ctrl_if.master bus
);

  localparam int CH_W = $clog2(N_CH) + 1;

  localparam logic [ADDR_W-1:0] c_W_LAST  = ADDR_W'(N_CH * W_WORDS - 1);
  localparam logic [ADDR_W-1:0] c_I_LAST  = ADDR_W'(I_WORDS - 1);
  localparam logic [ADDR_W-1:0] c_I_STEP  = ADDR_W'(I_WORDS);
  localparam logic [CH_W-1:0]   c_CH_LAST = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_W    = 3'd1,
    LOAD_I    = 3'd2,
    CONV_GO   = 3'd3,
    CONV_WAIT = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;     // word index within the current phase
  logic [ADDR_W-1:0] base_q, base_d;   // region offset of the current channel tile
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              wl_q, wl_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              sel_q, sel_d;
  logic              conv_start_q, conv_start_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              w_ack;
  logic              w_start_acc;

  // An ack only counts while a request is actually outstanding
  assign w_ack = rd_req_q & bus.rd_ack;

  // Next-state, counters and registered-output values; abort overrides everything
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    ch_d        = ch_q;
    wl_d        = wl_q;
    w_start_acc = 1'b0;

    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      base_d  = '0;
      ch_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_operation && !wl_q) begin
            state_d     = LOAD_W;
            cnt_d       = '0;
            base_d      = '0;
            w_start_acc = 1'b1;
          end else if (bus.start_load_img && wl_q) begin
            state_d     = LOAD_I;
            cnt_d       = '0;
            base_d      = '0;
            ch_d        = '0;
            w_start_acc = 1'b1;
          end else if (bus.clear_weights) begin
            wl_d = 1'b0;
          end
        end
        LOAD_W: begin
          if (w_ack) begin
            if (cnt_q == c_W_LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
              wl_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + ADDR_W'(1);
            end
          end
        end
        LOAD_I: begin
          if (w_ack) begin
            if (cnt_q == c_I_LAST) begin
              state_d = CONV_GO;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + ADDR_W'(1);
            end
          end
        end
        CONV_GO: begin
          state_d = CONV_WAIT;
        end
        CONV_WAIT: begin
          if (bus.conv_done) begin
            if (ch_q == c_CH_LAST) begin
              state_d = DONE;
            end else begin
              state_d = LOAD_I;
              ch_d    = ch_q + CH_W'(1);
              base_d  = base_q + c_I_STEP;
              cnt_d   = '0;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          ch_d    = '0;
          base_d  = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Outputs follow the next state so they are registered yet not lagging,
    // except conv_start which is issued from CONV_GO one cycle later
    rd_req_d     = (state_d == LOAD_W) || (state_d == LOAD_I);
    sel_d        = (state_d == LOAD_W);
    rd_addr_d    = base_d + cnt_d;
    conv_start_d = (state_q == CONV_GO) && !bus.abort;
    done_d       = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      ch_q         <= '0;
      wl_q         <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      sel_q        <= 1'b0;
      conv_start_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      ch_q         <= ch_d;
      wl_q         <= wl_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      sel_q        <= sel_d;
      conv_start_q <= conv_start_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.rd_req         = rd_req_q;
  assign bus.rd_addr        = rd_addr_q;
  assign bus.img_weight_sel = sel_q;
  assign bus.ch_idx         = ch_q;
  assign bus.conv_start     = conv_start_q;
  assign bus.weights_loaded = wl_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

`ifdef CONV_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  // Saturating count of busy cycles, restarted by every accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (w_start_acc) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  logic w_unused_perf;
  assign w_unused_perf   = w_start_acc;
  assign bus.perf_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_conv_seq_ctrl                                           |
// | Description : Self-checking bench for conv_seq_ctrl (3 channels, 9       |
// |               weight words per channel, 4-word image tiles).             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_conv_seq_ctrl;
  localparam int N_CH = 3;
  localparam int W_W  = 9;
  localparam int I_W  = 4;
  localparam int AW   = 12;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   busy_cyc;

  conv_seq_ctrl_if #(.N_CH(N_CH), .ADDR_W(AW)) bus ();

  conv_seq_ctrl #(
    .N_CH   (N_CH),
    .W_WORDS(W_W),
    .I_WORDS(I_W),
    .ADDR_W (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence wedges
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Full weight load with an ack every cycle; checks address ramp over all channels
  task automatic load_weights(input string tag);
    bus.start_operation = 1'b1;
    tick();
    bus.start_operation = 1'b0;
    for (int i = 0; i < N_CH * W_W; i++) begin
      chk({tag, "_req"}, 32'(bus.rd_req), 32'd1);
      chk({tag, "_sel"}, 32'(bus.img_weight_sel), 32'd1);
      chk({tag, "_addr"}, 32'(bus.rd_addr), 32'(i));
      chk({tag, "_wl_pre"}, 32'(bus.weights_loaded), 32'd0);
      bus.rd_ack = 1'b1;
      tick();
    end
    bus.rd_ack = 1'b0;
    chk({tag, "_wl"}, 32'(bus.weights_loaded), 32'd1);
    chk({tag, "_req_off"}, 32'(bus.rd_req), 32'd0);
    chk({tag, "_busy_off"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int stall;
    int d;
    bit ack;
    n_tests             = 0;
    n_fail              = 0;
    rst                 = 1'b0;
    bus.start_operation = 1'b0;
    bus.start_load_img  = 1'b0;
    bus.clear_weights   = 1'b0;
    bus.abort           = 1'b0;
    bus.rd_ack          = 1'b0;
    bus.conv_done       = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_req", 32'(bus.rd_req), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wl", 32'(bus.weights_loaded), 32'd0);
    chk("rst_perf", bus.perf_cycles, 32'd0);
    rst = 1'b1;
    tick();

    // T4: image start before weights are loaded is ignored
    bus.start_load_img = 1'b1;
    tick();
    bus.start_load_img = 1'b0;
    chk("t4_req", 32'(bus.rd_req), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("t4_req2", 32'(bus.rd_req), 32'd0);

    // T2: weight load, then a repeated start_operation is ignored
    load_weights("t2");
    bus.start_operation = 1'b1;
    tick();
    bus.start_operation = 1'b0;
    chk("t2_rep_busy", 32'(bus.busy), 32'd0);
    chk("t2_rep_req", 32'(bus.rd_req), 32'd0);
    tick();

    // T3: three channels with random ack stalls and random conv latency
    bus.start_load_img = 1'b1;
    tick();
    bus.start_load_img = 1'b0;
    busy_cyc = 0;
    for (int ch = 0; ch < N_CH; ch++) begin
      stall = 0;
      for (int w = 0; w < I_W; ) begin
        busy_cyc++;
        chk("t3_req", 32'(bus.rd_req), 32'd1);
        chk("t3_addr", 32'(bus.rd_addr), 32'(ch * I_W + w));
        chk("t3_sel", 32'(bus.img_weight_sel), 32'd0);
        chk("t3_ch", 32'(bus.ch_idx), 32'(ch));
        chk("t3_cs_idle", 32'(bus.conv_start), 32'd0);
        ack = ($urandom_range(0, 2) != 0) || (stall >= 3);
        stall = ack ? 0 : stall + 1;
        bus.rd_ack = ack;
        tick();
        if (ack) w++;
      end
      bus.rd_ack = 1'b0;
      // Cycle after the final ack: request gone, no conv_start yet
      busy_cyc++;
      chk("t3_req_off", 32'(bus.rd_req), 32'd0);
      chk("t3_cs_early", 32'(bus.conv_start), 32'd0);
      if (ch == 1) bus.conv_done = 1'b1;  // stray done before conv_start
      tick();
      bus.conv_done = 1'b0;
      busy_cyc++;
      chk("t3_cs", 32'(bus.conv_start), 32'd1);
      d = $urandom_range(1, 4);
      for (int k = 0; k < d; k++) begin
        tick();
        busy_cyc++;
        chk("t3_cs_wait", 32'(bus.conv_start), 32'd0);
        chk("t3_done_wait", 32'(bus.done), 32'd0);
        chk("t3_busy_wait", 32'(bus.busy), 32'd1);
      end
      bus.conv_done = 1'b1;
      tick();
      bus.conv_done = 1'b0;
    end
    busy_cyc++;
    chk("t3_done", 32'(bus.done), 32'd1);
    chk("t3_done_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("t3_done_once", 32'(bus.done), 32'd0);
    chk("t3_idle", 32'(bus.busy), 32'd0);
    chk("t3_ch_rst", 32'(bus.ch_idx), 32'd0);
    chk("t3_wl_kept", 32'(bus.weights_loaded), 32'd1);

    // T6: busy-cycle counter
`ifdef CONV_SEQ_PERF_CNT_EN
    chk("t6_perf", bus.perf_cycles, 32'(busy_cyc));
`else
    chk("t6_perf", bus.perf_cycles, 32'd0);
`endif
    tick();

    // T5: abort while waiting on channel 1's conv
    bus.start_load_img = 1'b1;
    tick();
    bus.start_load_img = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      for (int w = 0; w < I_W; w++) begin
        bus.rd_ack = 1'b1;
        tick();
      end
      bus.rd_ack = 1'b0;
      tick();
      tick();
      if (ch == 0) begin
        bus.conv_done = 1'b1;
        tick();
        bus.conv_done = 1'b0;
      end
    end
    chk("t5_ch1", 32'(bus.ch_idx), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_done", 32'(bus.done), 32'd0);
    chk("t5_wl", 32'(bus.weights_loaded), 32'd1);
    chk("t5_ch", 32'(bus.ch_idx), 32'd0);
    // Restart; clear_weights in the same cycle as an accepted start is dropped
    bus.start_load_img = 1'b1;
    bus.clear_weights  = 1'b1;
    tick();
    bus.start_load_img = 1'b0;
    bus.clear_weights  = 1'b0;
    chk("t5_rs_req", 32'(bus.rd_req), 32'd1);
    chk("t5_rs_addr", 32'(bus.rd_addr), 32'd0);
    chk("t5_rs_ch", 32'(bus.ch_idx), 32'd0);
    chk("t5_rs_wl", 32'(bus.weights_loaded), 32'd1);
    tick();

    // T1: asynchronous reset in the middle of LOAD_I
    #2 rst = 1'b0;
    #1;
    chk("t1_req", 32'(bus.rd_req), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_wl", 32'(bus.weights_loaded), 32'd0);
    chk("t1_addr", 32'(bus.rd_addr), 32'd0);
    chk("t1_cs", 32'(bus.conv_start), 32'd0);
    chk("t1_perf", bus.perf_cycles, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Abort during the weight phase leaves weights unloaded
    bus.start_operation = 1'b1;
    tick();
    bus.start_operation = 1'b0;
    bus.rd_ack = 1'b1;
    repeat (3) tick();
    bus.rd_ack = 1'b0;
    bus.abort  = 1'b1;
    tick();
    bus.abort  = 1'b0;
    chk("abw_wl", 32'(bus.weights_loaded), 32'd0);
    chk("abw_req", 32'(bus.rd_req), 32'd0);
    chk("abw_addr", 32'(bus.rd_addr), 32'd0);

    // Reload then clear_weights in IDLE
    load_weights("rl");
    bus.clear_weights = 1'b1;
    tick();
    bus.clear_weights = 1'b0;
    chk("clr_wl", 32'(bus.weights_loaded), 32'd0);
    chk("clr_busy", 32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
